// File: rtl/bcd_convert_seq_if.sv
// Handshake bundle for bcd_convert_seq: operand input channel and BCD result channel.
interface bcd_convert_seq_if #(
    parameter int unsigned BIN_W  = 12,
    parameter int unsigned DIGITS = 4
);
    localparam int unsigned BCD_W  = 4 * DIGITS;
    localparam int unsigned NDIG_W = $clog2(DIGITS + 1);

    logic              in_valid;
    logic              in_ready;
    logic [BIN_W-1:0]  in_data;
    logic              out_valid;
    logic              out_ready;
    logic [BCD_W-1:0]  out_bcd;
    logic [NDIG_W-1:0] out_ndig;
    logic              out_sign;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_bcd, out_ndig, out_sign
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_bcd, out_ndig, out_sign
    );
endinterface

// File: rtl/bcd_convert_seq.sv
// Sequential double-dabble binary-to-BCD converter, one shift per clock, valid/ready on both sides.
// Optional macro BCD_SIGNED_EN: treat in_data as two's complement and report the sign on out_sign.
module bcd_convert_seq #(
    parameter int unsigned BIN_W  = 12,
    parameter int unsigned DIGITS = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    bcd_convert_seq_if.slave  bus
);
    localparam int unsigned BCD_W  = 4 * DIGITS;
    localparam int unsigned SCR_W  = BCD_W + BIN_W;
    localparam int unsigned CNT_W  = $clog2(BIN_W + 1);
    localparam int unsigned NDIG_W = $clog2(DIGITS + 1);

    // True when DIGITS decimal digits can hold the largest BIN_W-bit value.
    function automatic bit digits_fit(input int unsigned bw, input int unsigned nd);
        logic [127:0] p10;
        logic [127:0] maxv;
        p10  = 128'd1;
        maxv = (128'd1 << bw) - 128'd1;
        for (int unsigned i = 0; i < nd; i++) begin
            if (p10 <= maxv) p10 = p10 * 128'd10;
        end
        return p10 > maxv;
    endfunction

    if (BIN_W < 4 || BIN_W > 32) begin : g_bad_width
        $error("bcd_convert_seq: BIN_W=%0d outside 4..32", BIN_W);
    end
    if (!digits_fit(BIN_W, DIGITS)) begin : g_bad_digits
        $error("bcd_convert_seq: DIGITS=%0d too small for BIN_W=%0d", DIGITS, BIN_W);
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [CNT_W-1:0]  cnt;
    logic [SCR_W-1:0]  scratch;
    logic [SCR_W-1:0]  scratch_adj;
    logic [SCR_W-1:0]  scratch_shift;
    logic [BCD_W-1:0]  bcd_res;
    logic [NDIG_W-1:0] ndig_res;
    logic [BIN_W-1:0]  operand;
    logic              accept;
    logic              step;
    logic              last;
    logic              in_ready_next;
    logic              out_valid_next;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (bus.in_valid) state_next = CONV;
            CONV:    if (cnt == CNT_W'(1)) state_next = DONE;
            DONE:    if (bus.out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Control outputs; handshake flags are registered from the next state
    always_comb begin
        accept         = 1'b0;
        step           = 1'b0;
        last           = 1'b0;
        in_ready_next  = (state_next == IDLE);
        out_valid_next = (state_next == DONE);
        unique case (state)
            IDLE:    accept = bus.in_valid;
            CONV: begin
                step = 1'b1;
                last = (cnt == CNT_W'(1));
            end
            DONE:    ;
            default: ;
        endcase
    end

`ifdef BCD_SIGNED_EN
    logic sign_stage;

    // Magnitude of the two's-complement input; the most negative value maps onto itself as unsigned.
    assign operand = bus.in_data[BIN_W-1] ? BIN_W'(-bus.in_data) : bus.in_data;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sign_stage   <= 1'b0;
            bus.out_sign <= 1'b0;
        end else begin
            if (accept) sign_stage   <= bus.in_data[BIN_W-1];
            if (last)   bus.out_sign <= sign_stage;
        end
    end
`else
    assign operand      = bus.in_data;
    assign bus.out_sign = 1'b0;
`endif

    // One double-dabble iteration: add 3 to every digit >= 5, then shift left
    always_comb begin
        scratch_adj = scratch;
        for (int unsigned d = 0; d < DIGITS; d++) begin
            if (scratch[BIN_W + 4*d +: 4] >= 4'd5)
                scratch_adj[BIN_W + 4*d +: 4] = scratch[BIN_W + 4*d +: 4] + 4'd3;
        end
        scratch_shift = {scratch_adj[SCR_W-2:0], 1'b0};
        bcd_res       = scratch_shift[SCR_W-1 -: BCD_W];
    end

    // Significant digit count from the most significant non-zero digit
    always_comb begin
        ndig_res = NDIG_W'(1);
        for (int unsigned d = 0; d < DIGITS; d++) begin
            if (bcd_res[4*d +: 4] != 4'd0) ndig_res = NDIG_W'(d + 1);
        end
    end

    // Datapath and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            scratch       <= '0;
            cnt           <= '0;
            bus.in_ready  <= 1'b1;
            bus.out_valid <= 1'b0;
            bus.out_bcd   <= '0;
            bus.out_ndig  <= NDIG_W'(1);
        end else begin
            bus.in_ready  <= in_ready_next;
            bus.out_valid <= out_valid_next;
            if (accept) begin
                scratch <= {BCD_W'(0), operand};
                cnt     <= CNT_W'(BIN_W);
            end else if (step) begin
                scratch <= scratch_shift;
                cnt     <= cnt - CNT_W'(1);
            end
            if (last) begin
                bus.out_bcd  <= bcd_res;
                bus.out_ndig <= ndig_res;
            end
        end
    end
endmodule

// File: doc/bcd_convert_seq.md
# bcd_convert_seq

Parametrised, sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) algorithm, one iteration per clock. It generalises the fixed 12-bit start/ready converter to configurable input width and digit count, with full valid/ready handshakes on both sides, output back-pressure, a significant-digit count for display blanking, and an optional two's-complement mode. It sits between arithmetic/counter logic and the seven-segment display driver.

## Interface
- BIN_W, 12, binary input width; legal 4..32
- DIGITS, 4, BCD output digits; must satisfy 10^DIGITS > 2^BIN_W − 1; elaboration raises $error otherwise
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- in_valid  in  1  input word present
- in_ready  out  1  block can accept a word
- in_data  in  BIN_W  binary value, captured on handshake
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result
- out_bcd  out  4*DIGITS  packed BCD, digit 0 in bits [3:0]
- out_ndig  out  $clog2(DIGITS+1)  significant digit count, 1..DIGITS
- out_sign  out  1  1 = negative (signed build only; constant 0 otherwise)

## Operation
- States: IDLE, CONV, DONE.
- IDLE: in_ready=1. On in_valid & in_ready: capture operand into shift register, clear BCD scratch, load iteration counter with BIN_W, go CONV.
- CONV: each cycle, for every digit ≥ 5 add 3, then shift {bcd, operand} left by one. Counter decrements; the cycle performing iteration BIN_W registers out_bcd, out_ndig, out_sign and goes DONE.
- DONE: out_valid=1, outputs stable. On out_ready → IDLE. If out_ready is low, hold indefinitely with outputs unchanged.
- in_ready is 1 only in IDLE; in_valid in CONV/DONE is ignored; in_data is don't-care outside the handshake cycle.
- out_ndig = 1 + index of the most significant non-zero digit; 1 for value 0.
- Arithmetic: scratch register is 4*DIGITS + BIN_W bits; add-3 is applied per 4-bit digit before the shift, never after the final shift.
- Reset (any state, including mid-CONV): state=IDLE, in_ready=1 after release, out_valid=0, out_bcd=0, out_ndig=1, out_sign=0, counter=0; any partial conversion is discarded.

## Timing
- Acceptance edge E0; out_valid rises after edge E0+BIN_W (latency BIN_W cycles; 12 at default).
- Result consumed at edge with out_valid & out_ready; in_ready rises the following cycle.
- Minimum issue interval with out_ready tied high: BIN_W + 2 cycles.
- No combinational path from in_valid to in_ready or from out_ready to out_valid.

## Configuration
- BCD_SIGNED_EN defined: in_data is two's complement. At capture, MSB goes to out_sign's staging register and the operand becomes |in_data| (−2^(BIN_W−1) converts to magnitude 2^(BIN_W−1), which fits BIN_W unsigned bits). Zero always yields out_sign=0. Latency unchanged.
- BCD_SIGNED_EN undefined: in_data unsigned, out_sign tied 0, no negation logic synthesised.

## Test plan
- Unsigned build, defaults: in_data=307 → out_bcd=16'h0307, out_ndig=3, out_valid exactly 12 cycles after acceptance.
- in_data=4095 → 16'h4095, out_ndig=4; in_data=0 → 16'h0000, out_ndig=1.
- in_data=2048, out_ready held low 5 cycles after out_valid → out_bcd stays 16'h2048, in_ready stays 0, a second in_valid is not accepted until after out_ready.
- Assert reset_n low at iteration 6 of converting 1365 → outputs to reset values immediately; after release, 819 converts to 16'h0819 correctly.
- BIN_W=16, DIGITS=5: in_data=65535 → 20'h65535, out_ndig=5, latency 16.
- BCD_SIGNED_EN, defaults: 12'hFFF → sign 1, 16'h0001; 12'h800 → sign 1, 16'h2048; 12'h7FF → sign 0, 16'h2047.
